// File: rtl/seg_pkg.sv
// Shared types and constants for the HEX scroll banner: character codes,
// the blank segment pattern and the controller state encoding.
package seg_pkg;

    typedef logic [4:0] char_t;

    localparam char_t CH_A     = 5'd10;
    localparam char_t CH_B     = 5'd11;
    localparam char_t CH_C     = 5'd12;
    localparam char_t CH_D     = 5'd13;
    localparam char_t CH_E     = 5'd14;
    localparam char_t CH_F     = 5'd15;
    localparam char_t CH_H     = 5'd16;
    localparam char_t CH_L     = 5'd17;
    localparam char_t CH_O     = 5'd18;
    localparam char_t CH_P     = 5'd19;
    localparam char_t CH_R     = 5'd20;
    localparam char_t CH_U     = 5'd21;
    localparam char_t CH_MINUS = 5'd22;
    localparam char_t CH_BLANK = 5'd31;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/seg_char_decoder.sv
// Character code to active-low seven-segment pattern (bit order gfedcba).
// Reserved codes 23..30 and code 31 decode to blank.
module seg_char_decoder
    import seg_pkg::*;
(
    input  char_t       char_i,
    output logic [6:0]  seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (char_i)
            5'd0:     seg_o = 7'b1000000;
            5'd1:     seg_o = 7'b1111001;
            5'd2:     seg_o = 7'b0100100;
            5'd3:     seg_o = 7'b0110000;
            5'd4:     seg_o = 7'b0011001;
            5'd5:     seg_o = 7'b0010010;
            5'd6:     seg_o = 7'b0000010;
            5'd7:     seg_o = 7'b1111000;
            5'd8:     seg_o = 7'b0000000;
            5'd9:     seg_o = 7'b0010000;
            CH_A:     seg_o = 7'b0001000;
            CH_B:     seg_o = 7'b0000011;
            CH_C:     seg_o = 7'b1000110;
            CH_D:     seg_o = 7'b0100001;
            CH_E:     seg_o = 7'b0000110;
            CH_F:     seg_o = 7'b0001110;
            CH_H:     seg_o = 7'b0001001;
            CH_L:     seg_o = 7'b1000111;
            CH_O:     seg_o = 7'b0100011;
            CH_P:     seg_o = 7'b0001100;
            CH_R:     seg_o = 7'b0101111;
            CH_U:     seg_o = 7'b1000001;
            CH_MINUS: seg_o = 7'b0111111;
            default:  seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_scroll_controller.sv
// Right-to-left scrolling banner across HEX0..HEX(NUM_DIGITS-1).
// Optional SEG_SCROLL_STOP_EN adds stop_i to abort a run from RUN.
//
// state | meaning
// IDLE  | display blank, buffer writable, waiting for a valid start
// RUN   | stepping s once per prescaler wrap, buffer frozen
module hex_scroll_controller
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int MSG_LEN    = 16,
    parameter int TICK_DIV   = 12_500_000
)
(
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          load_en_i,
    input  logic [$clog2(MSG_LEN)-1:0]    load_addr_i,
    input  char_t                         load_char_i,
    input  logic [$clog2(MSG_LEN):0]      len_i,
    input  logic                          loop_i,
    input  logic                          start_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [7*NUM_DIGITS-1:0]       hex_o
`ifdef SEG_SCROLL_STOP_EN
    ,
    input  logic                          stop_i
`endif
);

    localparam int AW = $clog2(MSG_LEN);
    localparam int LW = AW + 1;
    localparam int SW = $clog2(MSG_LEN + NUM_DIGITS);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    state_t                   r_state;
    logic [SW-1:0]            r_step;
    logic [PW-1:0]            r_presc;
    logic [LW-1:0]            r_len;
    logic                     r_loop;
    char_t                    r_buf [MSG_LEN];
    logic                     r_busy;
    logic                     r_done;
    logic [7*NUM_DIGITS-1:0]  r_hex;

    logic                     w_tick;
    logic                     w_last;
    logic                     w_start_ok;
    logic                     w_stop;
    char_t                    w_char [NUM_DIGITS];
    logic [6:0]               w_seg  [NUM_DIGITS];
    logic [7*NUM_DIGITS-1:0]  w_hex_run;

`ifdef SEG_SCROLL_STOP_EN
    assign w_stop = stop_i;
`else
    assign w_stop = 1'b0;
`endif

    assign w_tick     = (r_presc == PRESC_MAX);
    assign w_last     = (int'(r_step) == int'(r_len) + NUM_DIGITS - 1);
    assign w_start_ok = start_i && (len_i != '0) && (len_i <= LW'(MSG_LEN));

    // Digit d shows buffer[s-d] while that index lies inside the message.
    always_comb begin
        for (int d = 0; d < NUM_DIGITS; d++) begin
            w_char[d] = CH_BLANK;
            if ((int'(r_step) >= d) && ((int'(r_step) - d) < int'(r_len)))
                w_char[d] = r_buf[AW'(int'(r_step) - d)];
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        seg_char_decoder u_dec (
            .char_i (w_char[g]),
            .seg_o  (w_seg[g])
        );
        assign w_hex_run[7*g +: 7] = w_seg[g];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_step  <= '0;
            r_presc <= '0;
            r_len   <= '0;
            r_loop  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hex   <= {NUM_DIGITS{SEG_BLANK}};
            for (int i = 0; i < MSG_LEN; i++)
                r_buf[i] <= CH_BLANK;
        end else begin
            r_done <= 1'b0;
            r_hex  <= (r_state == RUN) ? w_hex_run : {NUM_DIGITS{SEG_BLANK}};
            case (r_state)
                IDLE: begin
                    if (load_en_i)
                        r_buf[load_addr_i] <= load_char_i;
                    if (w_start_ok) begin
                        r_len   <= len_i;
                        r_loop  <= loop_i;
                        r_step  <= '0;
                        r_presc <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    // Abort wins over a tick landing in the same cycle.
                    if (w_stop) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_step  <= '0;
                        r_presc <= '0;
                    end else if (w_tick) begin
                        r_presc <= '0;
                        if (w_last) begin
                            r_step <= '0;
                            if (!r_loop) begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_step <= r_step + SW'(1);
                        end
                    end else begin
                        r_presc <= r_presc + PW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy_o = r_busy;
    assign done_o = r_done;
    assign hex_o  = r_hex;

endmodule
